// File: rtl/centroid_update.sv
// ---------------------------------------------------------------------------
// centroid_update
//   Final stage of the k-means assignment/accumulate block. It takes the
//   per-cluster coordinate sums and member counts from one pass over the
//   dataset. It divides them to form new centroids c1..c3 and reports
//   whether the new centroids match the previous ones.
//   One restoring divider is shared over 3 clusters x 2 axes, in the order
//   k0.x, k0.y, k1.x, k1.y, k2.x, k2.y.
//
//   Optional feature macro: CENTROID_ROUND_EN
//     defined   -> quotient rounds to nearest, q + (2*rem >= count)
//     undefined -> quotient truncates toward zero
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   start      begin an update (sampled only in IDLE)
//   load_init  load init_bus into c1..c3 (sampled only in IDLE, beats start)
//   init_bus   {c3,c2,c1} initial centroids
//   sum_x_bus  {sx2,sx1,sx0} per-cluster x sums
//   sum_y_bus  {sy2,sy1,sy0} per-cluster y sums
//   count_bus  {n2,n1,n0} per-cluster member counts
//   c1,c2,c3   current centroids {x,y}, registered
//   busy       high from start accept until the done cycle ends
//   done       one-cycle pulse, new centroids valid
//   converged  last update left all centroids unchanged
//   iter_count completed updates since reset/load_init, saturating
// ---------------------------------------------------------------------------
module centroid_update #(
  parameter int COORD_W  = 8,
  parameter int SUM_W    = 16,
  parameter int CNT_W    = 8,
  parameter int MAX_ITER = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 load_init,
  input  logic [6*COORD_W-1:0] init_bus,
  input  logic [3*SUM_W-1:0]   sum_x_bus,
  input  logic [3*SUM_W-1:0]   sum_y_bus,
  input  logic [3*CNT_W-1:0]   count_bus,
  output logic [2*COORD_W-1:0] c1,
  output logic [2*COORD_W-1:0] c2,
  output logic [2*COORD_W-1:0] c3,
  output logic                 busy,
  output logic                 done,
  output logic                 converged,
  output logic [3:0]           iter_count
);

  localparam int CW2    = 2 * COORD_W;
  localparam int STEP_W = $clog2(SUM_W + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_CMP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [2:0]        ax_q, ax_d;        // axis index 0..5
  logic [STEP_W-1:0] step_q, step_d;    // 0 = load, 1..SUM_W = shift/subtract
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [SUM_W-1:0]  quo_q, quo_d;
  logic [SUM_W-1:0]  sx_q [3], sx_d [3];
  logic [SUM_W-1:0]  sy_q [3], sy_d [3];
  logic [CNT_W-1:0]  n_q  [3], n_d  [3];
  logic [CW2-1:0]    cen_q [3], cen_d [3];
  logic [CW2-1:0]    shd_q [3], shd_d [3];
  logic              conv_q, conv_d;
  logic [3:0]        iter_q, iter_d;

  // Operands of the axis currently being divided.
  logic [1:0]       k_sel;
  logic [SUM_W-1:0] cur_sum;
  logic [CNT_W-1:0] cur_cnt;
  logic [CNT_W:0]   rem_sh;
  logic             ge;
  logic [CNT_W-1:0] rem_nx;
  logic [SUM_W-1:0] quo_nx;
  logic [SUM_W:0]   q_full;
  logic [COORD_W-1:0] coord;
  logic             all_same;

  assign k_sel   = ax_q[2:1];
  assign cur_sum = ax_q[0] ? sy_q[k_sel] : sx_q[k_sel];
  assign cur_cnt = n_q[k_sel];

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // The remainder stays below the divisor, so CNT_W bits always hold it.
  assign rem_sh = {rem_q, quo_q[SUM_W-1]};
  assign ge     = rem_sh >= {1'b0, cur_cnt};
  assign rem_nx = ge ? CNT_W'(rem_sh - {1'b0, cur_cnt}) : rem_sh[CNT_W-1:0];
  assign quo_nx = {quo_q[SUM_W-2:0], ge};

`ifdef CENTROID_ROUND_EN
  logic round_up;
  assign round_up = {rem_nx, 1'b0} >= {1'b0, cur_cnt};
  assign q_full   = {1'b0, quo_nx} + {{SUM_W{1'b0}}, round_up};
`else
  assign q_full   = {1'b0, quo_nx};
`endif

  // Anything that does not fit a coordinate clamps to all-ones.
  assign coord = (q_full[SUM_W:COORD_W] != '0) ? {COORD_W{1'b1}}
                                                 : q_full[COORD_W-1:0];

  always_comb begin
    all_same = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (shd_q[k] != cen_q[k]) all_same = 1'b0;
    end
  end

  always_comb begin
    // NOTE: every always_comb target gets a hold default first so that no
    // path through the case leaves it unassigned and infers a latch.
    state_d = state_q;
    ax_d    = ax_q;
    step_d  = step_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    n_d     = n_q;
    cen_d   = cen_q;
    shd_d   = shd_q;
    conv_d  = conv_q;
    iter_d  = iter_q;

    case (state_q)
      S_IDLE: begin
        if (load_init) begin
          for (int k = 0; k < 3; k++) cen_d[k] = init_bus[k*CW2 +: CW2];
          iter_d = '0;
          conv_d = 1'b0;
        end else if (start) begin
          for (int k = 0; k < 3; k++) begin
            sx_d[k] = sum_x_bus[k*SUM_W +: SUM_W];
            sy_d[k] = sum_y_bus[k*SUM_W +: SUM_W];
            n_d[k]  = count_bus[k*CNT_W +: CNT_W];
          end
          shd_d   = cen_q;  // empty clusters keep their old coordinates
          ax_d    = '0;
          step_d  = '0;
          state_d = S_DIV;
        end
      end

      S_DIV: begin
        if (step_q == '0) begin
          if (cur_cnt == '0) begin
            // Empty cluster: skip the divide, shadow keeps the old value.
            if (ax_q == 3'd5) state_d = S_CMP;
            else              ax_d    = ax_q + 3'd1;
          end else begin
            rem_d  = '0;
            quo_d  = cur_sum;
            step_d = STEP_W'(1);
          end
        end else begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          if (step_q == STEP_W'(SUM_W)) begin
            if (ax_q[0]) shd_d[k_sel][COORD_W-1:0]   = coord;
            else         shd_d[k_sel][CW2-1:COORD_W] = coord;
            step_d = '0;
            if (ax_q == 3'd5) state_d = S_CMP;
            else              ax_d    = ax_q + 3'd1;
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end
      end

      S_CMP: begin
        cen_d  = shd_q;
        conv_d = all_same;
        if (iter_q != 4'(MAX_ITER)) iter_d = iter_q + 4'd1;
        state_d = S_DONE;
      end

      default: state_d = S_IDLE;  // S_DONE
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ax_q    <= '0;
      step_q  <= '0;
      cen_q[0] <= CW2'(16'h0001);
      cen_q[1] <= CW2'(16'h0802);
      cen_q[2] <= CW2'(16'h0003);
      conv_q  <= 1'b0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      ax_q    <= ax_d;
      step_q  <= step_d;
      cen_q   <= cen_d;
      conv_q  <= conv_d;
      iter_q  <= iter_d;
    end
  end

  // NOTE: operand snapshots, shadow centroids and divider datapath are left
  // unreset on purpose. Each is written before it is read in every update.
  always_ff @(posedge clk) begin
    rem_q <= rem_d;
    quo_q <= quo_d;
    sx_q  <= sx_d;
    sy_q  <= sy_d;
    n_q   <= n_d;
    shd_q <= shd_d;
  end

  assign c1         = cen_q[0];
  assign c2         = cen_q[1];
  assign c3         = cen_q[2];
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign converged  = conv_q;
  assign iter_count = iter_q;

endmodule

// File: tb/tb_centroid_update.sv
// ---------------------------------------------------------------------------
// tb_centroid_update
//   Directed, table-driven bench for centroid_update. Each table row holds
//   one update's inputs plus the hand-computed centroids, done latency,
//   converged flag and iter_count expected afterwards. Hand-written sequences
//   cover the following cases:
//     - iter_count saturation
//     - start/load_init ignored while busy
//     - reset in the middle of DIV
//     - load_init winning over start
// ---------------------------------------------------------------------------
module tb_centroid_update;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        load_init;
  logic [47:0] init_bus;
  logic [47:0] sum_x_bus;
  logic [47:0] sum_y_bus;
  logic [23:0] count_bus;
  logic [15:0] c1, c2, c3;
  logic        busy, done, converged;
  logic [3:0]  iter_count;

  int n_checks = 0;
  int n_fail   = 0;

  centroid_update dut (
    .clk(clk), .reset(reset), .start(start), .load_init(load_init),
    .init_bus(init_bus), .sum_x_bus(sum_x_bus), .sum_y_bus(sum_y_bus),
    .count_bus(count_bus), .c1(c1), .c2(c2), .c3(c3), .busy(busy),
    .done(done), .converged(converged), .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] sx;
    logic [47:0] sy;
    logic [23:0] n;
    logic [15:0] e1, e2, e3;
    int          lat;
    logic        conv;
    logic [3:0]  iter;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Run one update. Inputs are scrambled mid-run to prove they were
  // snapshotted. If inject_at > 0, start+load_init are pulsed at that cycle.
  task automatic run_update(input vec_t v, input int inject_at);
    logic [15:0] o1, o2, o3;
    int  n;
    bit  seen, stable, busy_ok;
    @(negedge clk);
    sum_x_bus = v.sx; sum_y_bus = v.sy; count_bus = v.n;
    start = 1'b1;
    o1 = c1; o2 = c2; o3 = c3;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1; seen = 0; stable = 1; busy_ok = 1;
    while (!seen && n < 200) begin
      if (done) begin
        seen = 1;
      end else begin
        if (c1 !== o1 || c2 !== o2 || c3 !== o3) stable = 0;
        if (busy !== 1'b1) busy_ok = 0;
        if (n == 3) begin
          sum_x_bus = 48'h1234_5678_9ABC; sum_y_bus = '1; count_bus = 24'h010101;
        end
        if (inject_at > 0 && n == inject_at) begin
          start = 1'b1; load_init = 1'b1; init_bus = 48'h0011_0022_0033;
        end
        if (inject_at > 0 && n == inject_at + 1) begin
          start = 1'b0; load_init = 1'b0;
        end
        @(posedge clk); #1;
        n++;
      end
    end
    check("done_latency", n, v.lat);
    check("c_stable_busy", stable, 1);
    check("busy_during", busy_ok && busy, 1);
    check("c1", c1, v.e1);
    check("c2", c2, v.e2);
    check("c3", c3, v.e3);
    check("converged", converged, v.conv);
    check("iter_count", iter_count, v.iter);
    @(posedge clk); #1;
    check("done_pulse_end", {busy, done}, 2'b00);
  endtask

  task automatic check_reset_vals();
    check("rst_c1", c1, 16'h0001);
    check("rst_c2", c2, 16'h0802);
    check("rst_c3", c3, 16'h0003);
    check("rst_busy_done", {busy, done}, 2'b00);
    check("rst_conv", converged, 1'b0);
    check("rst_iter", iter_count, 4'd0);
  endtask

  initial begin
    vec_t z;
    logic [15:0] e1_rnd;
`ifdef CENTROID_ROUND_EN
    e1_rnd = 16'h0406;  // 7/2 = 3.5 rounds up
`else
    e1_rnd = 16'h0306;  // 7/2 truncates to 3
`endif
    // k0: 30/3,12/3  k1: 40/4,20/4  k2: 9/9,27/9
    vecs[0] = '{48'h0009_0028_001E, 48'h001B_0014_000C, 24'h09_04_03,
                16'h0A04, 16'h0A05, 16'h0103, 104, 1'b0, 4'd1};
    vecs[1] = '{48'h0009_0028_001E, 48'h001B_0014_000C, 24'h09_04_03,
                16'h0A04, 16'h0A05, 16'h0103, 104, 1'b1, 4'd2};
    // n1 = 0: cluster 1 keeps its centroid, two axes skipped
    vecs[2] = '{48'h0009_0028_001E, 48'h001B_0014_000C, 24'h09_00_03,
                16'h0A04, 16'h0A05, 16'h0103, 72, 1'b1, 4'd3};
    // k0: 7/2,12/2  k1: FFFF/1 saturates, 0/1  k2 empty
    vecs[3] = '{48'h0009_FFFF_0007, 48'h001B_0000_000C, 24'h00_01_02,
                e1_rnd, 16'hFF00, 16'h0103, 72, 1'b0, 4'd4};
    // every cluster empty: six one-cycle skips
    vecs[4] = '{48'h0009_FFFF_0007, 48'h001B_0000_000C, 24'h00_00_00,
                e1_rnd, 16'hFF00, 16'h0103, 8, 1'b1, 4'd5};

    reset = 1'b1; start = 1'b0; load_init = 1'b0; init_bus = '0;
    sum_x_bus = '0; sum_y_bus = '0; count_bus = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_vals();

    for (int i = 0; i < 5; i++) run_update(vecs[i], 0);

    // iter_count saturates at 15.
    z = vecs[4];
    for (int i = 0; i < 11; i++) begin
      z.iter = (6 + i > 15) ? 4'd15 : 4'(6 + i);
      run_update(z, 0);
    end

    // start/load_init while busy are ignored and not queued.
    z = vecs[0];
    z.conv = 1'b0; z.iter = 4'd15;
    run_update(z, 20);
    repeat (3) begin
      @(posedge clk); #1;
      check("no_queued_start", busy, 1'b0);
    end

    // Reset in the middle of DIV aborts the update.
    @(negedge clk);
    sum_x_bus = vecs[0].sx; sum_y_bus = vecs[0].sy; count_bus = vecs[0].n;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (49) @(posedge clk);
    #1 check("busy_before_rst", busy, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_vals();

    // Get converged=1 first so the load visibly clears it.
    z = vecs[4];
    z.e1 = 16'h0001; z.e2 = 16'h0802; z.e3 = 16'h0003;
    z.conv = 1'b1; z.iter = 4'd1;
    run_update(z, 0);

    // load_init and start together in IDLE: load wins, start dropped.
    @(negedge clk);
    load_init = 1'b1; start = 1'b1; init_bus = 48'h0003_0002_0001;
    @(posedge clk); #1;
    load_init = 1'b0; start = 1'b0;
    check("load_c1", c1, 16'h0001);
    check("load_c2", c2, 16'h0002);
    check("load_c3", c3, 16'h0003);
    check("load_iter", iter_count, 4'd0);
    check("load_conv", converged, 1'b0);
    check("load_no_start", busy, 1'b0);
    @(posedge clk); #1;
    check("load_still_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
